// File: rtl/uart_tx_module_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Definitions shared by the UART transmit path: the state encoding of the
// transmitter FSM, the frame constants, and the helper that derives the
// number of system clocks per serial bit from the clock and baud rates.
//
// Optional feature macro referenced by users of this package:
//   UART_TX_PARITY_EN - when defined, the transmitter inserts an even
//                       parity bit between the data bits and the stop bit.
//                       The PARITY encoding is always present so the state
//                       register layout is identical in both builds.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Number of payload bits in one 8N1 character.
    localparam int DATA_BITS = 8;

    // Level of the serial line while no frame is in flight (mark state).
    localparam logic IDLE_LEVEL = 1'b1;

    // Transmitter FSM encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } tx_state_t;

    // Clocks per serial bit. Truncating division: a small residual baud
    // error is accepted rather than adding a fractional accumulator.
    function automatic int calc_bps_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_module_if.sv
// ---------------------------------------------------------------------------
// uart_tx_module_if
//
// Handshake and line signals of the UART transmitter. Clock and reset are
// kept outside the interface as plain ports of the design.
//
// Signals:
//   TX_En_Sig   - start request from the producer (level, sampled in IDLE)
//   TX_Data     - byte to send, captured on the accepting cycle
//   TX_Pin_Out  - serial line towards the receiver, idle high
//   TX_Busy_Sig - frame in flight (cycle after acceptance through DONE)
//   TX_Done_Sig - one-cycle pulse at the end of each frame
//
// Modports:
//   master - producer side (drives request and data, observes status)
//   slave  - transmitter side (the uart_tx_module itself)
// ---------------------------------------------------------------------------
interface uart_tx_module_if;
    import uart_pkg::*;

    logic                 TX_En_Sig;
    logic [DATA_BITS-1:0] TX_Data;
    logic                 TX_Pin_Out;
    logic                 TX_Busy_Sig;
    logic                 TX_Done_Sig;

    modport master (
        output TX_En_Sig,
        output TX_Data,
        input  TX_Pin_Out,
        input  TX_Busy_Sig,
        input  TX_Done_Sig
    );

    modport slave (
        input  TX_En_Sig,
        input  TX_Data,
        output TX_Pin_Out,
        output TX_Busy_Sig,
        output TX_Done_Sig
    );

endinterface

// File: rtl/uart_tx_module_bps.sv
// ---------------------------------------------------------------------------
// tx_bps_module
//
// Baud-tick generator for the UART transmitter. The counter only runs while
// the transmitter is inside a frame; outside a frame it is held at zero so
// every frame starts from a clean bit boundary.
//
// Parameters:
//   BPS_DIV     - system clocks per serial bit (must be >= 4)
//
// Ports:
//   CLK         - system clock, rising edge
//   Rstn        - asynchronous active-low reset
//   Count_Sig   - high while the FSM is in START/DATA/PARITY/STOP
//   BPS_End_Sig - one-cycle pulse on the last clock of each bit period
// ---------------------------------------------------------------------------
module tx_bps_module #(
    parameter int BPS_DIV = 5208
) (
    input  logic CLK,
    input  logic Rstn,
    input  logic Count_Sig,
    output logic BPS_End_Sig
);

    localparam int               CNT_W    = $clog2(BPS_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_DIV - 1);

    logic [CNT_W-1:0] bps_cnt;

    // The counter wraps to zero on the same edge the FSM changes state, so
    // each state is entered with the counter already at zero; dropping
    // Count_Sig also forces it back to zero.
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            bps_cnt <= '0;
        end else if (!Count_Sig) begin
            bps_cnt <= '0;
        end else if (bps_cnt == CNT_LAST) begin
            bps_cnt <= '0;
        end else begin
            bps_cnt <= bps_cnt + CNT_W'(1);
        end
    end

    assign BPS_End_Sig = Count_Sig && (bps_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_module.sv
// ---------------------------------------------------------------------------
// uart_tx_module
//
// Serial 8N1 UART transmitter. One byte is accepted per start request while
// idle, sent LSB-first at a fixed baud rate, and completion is flagged with
// a one-cycle done pulse. All outputs are registered; the line is idle high.
//
// Frame on the line (BPS_DIV clocks per bit):
//   start(0) d0 d1 d2 d3 d4 d5 d6 d7 [parity] stop(1)
// followed by one DONE cycle and one IDLE cycle before the next start bit
// can appear.
//
// Configuration macro:
//   UART_TX_PARITY_EN - when defined, an even parity bit (XOR of the eight
//                       captured bits) is sent between d7 and the stop bit.
//
// Parameters:
//   CLK_FREQ - system clock frequency in Hz
//   BAUD     - line bit rate in bit/s
//   BPS_DIV  - clocks per bit, derived from the two above (must be >= 4)
//
// Ports:
//   CLK   - system clock, rising edge
//   Rstn  - asynchronous active-low reset; aborts a frame immediately
//   tx_if - transmitter side of uart_tx_module_if (request, data, line,
//           busy and done)
// ---------------------------------------------------------------------------
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int BPS_DIV  = calc_bps_div(CLK_FREQ, BAUD)
) (
    input  logic          CLK,
    input  logic          Rstn,
    uart_tx_module_if.slave tx_if
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           bit_idx;
    logic [2:0]           next_idx;
    logic                 tx_pin;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 count_sig;
    logic                 bps_end;

    // Baud counter runs only while a bit is actually on the line.
    assign count_sig = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);

    assign next_idx = bit_idx + 3'd1;

    tx_bps_module #(
        .BPS_DIV     (BPS_DIV)
    ) u_bps (
        .CLK         (CLK),
        .Rstn        (Rstn),
        .Count_Sig   (count_sig),
        .BPS_End_Sig (bps_end)
    );

    // Transmitter FSM. The line level for each bit is loaded on the same
    // edge that enters the bit's state, so the registered pin output lines
    // up exactly with the state and no combinational path reaches the pin.
    // The bit index wrap from 7 is never relied on; the DATA exit is
    // decided by comparing against the last index.
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_pin    <= IDLE_LEVEL;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_pin  <= IDLE_LEVEL;
                    tx_busy <= 1'b0;
                    if (tx_if.TX_En_Sig) begin
                        shift_reg <= tx_if.TX_Data;
                        bit_idx   <= '0;
                        tx_pin    <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end

                START: begin
                    if (bps_end) begin
                        bit_idx <= '0;
                        tx_pin  <= shift_reg[0];
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (bps_end) begin
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            tx_pin <= ^shift_reg;
                            state  <= PARITY;
`else
                            tx_pin <= IDLE_LEVEL;
                            state  <= STOP;
`endif
                        end else begin
                            bit_idx <= next_idx;
                            tx_pin  <= shift_reg[next_idx];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bps_end) begin
                        tx_pin <= IDLE_LEVEL;
                        state  <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (bps_end) begin
                        tx_pin  <= IDLE_LEVEL;
                        tx_done <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    tx_pin  <= IDLE_LEVEL;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end

                // Unreachable encodings (and PARITY when the feature is
                // compiled out) recover to a quiet idle line.
                default: begin
                    tx_pin  <= IDLE_LEVEL;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign tx_if.TX_Pin_Out  = tx_pin;
    assign tx_if.TX_Busy_Sig = tx_busy;
    assign tx_if.TX_Done_Sig = tx_done;

endmodule

// File: tb/tb_uart_tx_module.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_module
//
// Directed self-checking bench for uart_tx_module with CLK_FREQ=1600 and
// BAUD=100, i.e. 16 clocks per bit. Outputs are sampled 1 time unit after
// each rising clock edge. Build with UART_TX_PARITY_EN defined to exercise
// the parity bit as well.
// ---------------------------------------------------------------------------
module tb_uart_tx_module;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int BPS      = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic CLK  = 1'b0;
    logic Rstn = 1'b0;

    int checkCount = 0;
    int errorCount = 0;

    // Line level sampled in the middle of each bit of the last frame.
    logic midLevel [0:10];

    uart_tx_module_if tx_if();

    uart_tx_module #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .CLK      (CLK),
        .Rstn     (Rstn),
        .tx_if    (tx_if)
    );

    always #5 CLK = ~CLK;

    // Guards against a hung run; every test is a fixed number of cycles.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to the sampling point just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request for one clock; returns at sample 0 of the frame,
    // just after the accepting edge. With holdEn the request stays high.
    task automatic applyStimulus(input logic [7:0] data, input bit holdEn);
        tx_if.TX_Data   = data;
        tx_if.TX_En_Sig = 1'b1;
        tick();
        if (!holdEn) tx_if.TX_En_Sig = 1'b0;
    endtask

    // Reference line level for bit position b of a frame carrying byteVal.
    function automatic logic expLevel(input logic [7:0] byteVal, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return byteVal[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^byteVal;
`endif
        return 1'b1;
    endfunction

    function automatic logic [7:0] decodeMid();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = midLevel[i+1];
        return d;
    endfunction

    // Walks one whole frame starting at sample 0, then checks the DONE cycle
    // and the following IDLE cycle; returns at that IDLE sample. When
    // pokeAt >= 0 a second request with a different byte is pulsed at that
    // cycle of the frame.
    task automatic checkFrame(input logic [7:0] expByte, input int pokeAt,
                              input string tag);
        int   busyCnt;
        int   doneCnt;
        int   cyc;
        int   matchCnt;
        logic lvl;
        busyCnt = 0;
        doneCnt = 0;
        cyc     = 0;
        for (int b = 0; b < FRAME_BITS; b++) begin
            matchCnt = 0;
            lvl      = expLevel(expByte, b);
            for (int c = 0; c < BPS; c++) begin
                if (tx_if.TX_Pin_Out === lvl) matchCnt++;
                if (tx_if.TX_Busy_Sig === 1'b1) busyCnt++;
                if (tx_if.TX_Done_Sig !== 1'b0) doneCnt++;
                if (c == BPS / 2) midLevel[b] = tx_if.TX_Pin_Out;
                if (pokeAt >= 0 && cyc == pokeAt) begin
                    tx_if.TX_Data   = 8'hC3;
                    tx_if.TX_En_Sig = 1'b1;
                end else if (pokeAt >= 0 && cyc == pokeAt + 1) begin
                    tx_if.TX_En_Sig = 1'b0;
                end
                cyc++;
                tick();
            end
            checkOutput($sformatf("%s_bit%0d_cycles", tag, b), matchCnt, BPS);
        end
        checkOutput({tag, "_busy_cycles"}, busyCnt, BPS * FRAME_BITS);
        checkOutput({tag, "_early_done"}, doneCnt, 0);
        checkOutput({tag, "_done_pulse"}, tx_if.TX_Done_Sig, 1);
        checkOutput({tag, "_done_busy"}, tx_if.TX_Busy_Sig, 1);
        checkOutput({tag, "_done_line"}, tx_if.TX_Pin_Out, 1);
        tick();
        checkOutput({tag, "_done_fall"}, tx_if.TX_Done_Sig, 0);
        checkOutput({tag, "_busy_fall"}, tx_if.TX_Busy_Sig, 0);
        checkOutput({tag, "_idle_line"}, tx_if.TX_Pin_Out, 1);
    endtask

    // Counts cycles where the transmitter is fully quiet.
    task automatic checkQuiet(input int cycles, input string tag);
        int quietCnt;
        quietCnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_if.TX_Pin_Out === 1'b1 && tx_if.TX_Busy_Sig === 1'b0 &&
                tx_if.TX_Done_Sig === 1'b0) quietCnt++;
            tick();
        end
        checkOutput(tag, quietCnt, cycles);
    endtask

    initial begin
        int doneSeen;

        tx_if.TX_En_Sig = 1'b0;
        tx_if.TX_Data   = 8'h00;
        Rstn            = 1'b0;

        // Reset state, request asserted to show reset wins.
        tx_if.TX_En_Sig = 1'b1;
        repeat (5) tick();
        checkOutput("rst_line", tx_if.TX_Pin_Out, 1);
        checkOutput("rst_busy", tx_if.TX_Busy_Sig, 0);
        checkOutput("rst_done", tx_if.TX_Done_Sig, 0);
        tx_if.TX_En_Sig = 1'b0;
        Rstn = 1'b1;

        // No request: quiet line for 200 cycles.
        checkQuiet(200, "idle_200");

        // Single frame A5: 1,0,1,0,0,1,0,1 on the line LSB first.
        applyStimulus(8'hA5, 1'b0);
        checkFrame(8'hA5, -1, "a5");
        checkOutput("a5_decoded", decodeMid(), 8'hA5);
        checkOutput("a5_start_mid", midLevel[0], 0);
        checkOutput("a5_bit1_mid", midLevel[2], 0);

        // Back-to-back with the request held high: 00 then FF.
        applyStimulus(8'h00, 1'b1);
        tx_if.TX_Data = 8'hFF;
        checkFrame(8'h00, -1, "b2b0");
        checkOutput("b2b0_decoded", decodeMid(), 8'h00);
        tick();
        tx_if.TX_En_Sig = 1'b0;
        checkOutput("b2b_gap_start_low", tx_if.TX_Pin_Out, 0);
        checkFrame(8'hFF, -1, "b2b1");
        checkOutput("b2b1_decoded", decodeMid(), 8'hFF);
        checkQuiet(20, "b2b_after_quiet");

        // Request and new data mid-frame are ignored; one frame, one done.
        applyStimulus(8'h3C, 1'b0);
        checkFrame(8'h3C, 40, "poke");
        checkOutput("poke_decoded", decodeMid(), 8'h3C);
        checkQuiet(40, "poke_no_extra_frame");

        // Reset in the middle of data bit 4 (a zero bit of 0F).
        applyStimulus(8'h0F, 1'b0);
        repeat (BPS + 4 * BPS + 5) tick();
        checkOutput("abort_pre_line", tx_if.TX_Pin_Out, 0);
        #2;
        Rstn = 1'b0;
        #1;
        checkOutput("abort_line_async", tx_if.TX_Pin_Out, 1);
        checkOutput("abort_busy_async", tx_if.TX_Busy_Sig, 0);
        doneSeen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx_if.TX_Done_Sig !== 1'b0) doneSeen++;
        end
        Rstn = 1'b1;
        tick();
        if (tx_if.TX_Done_Sig !== 1'b0) doneSeen++;
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_idle_line", tx_if.TX_Pin_Out, 1);

        applyStimulus(8'h55, 1'b0);
        checkFrame(8'h55, -1, "after_abort");
        checkOutput("after_abort_decoded", decodeMid(), 8'h55);

`ifdef UART_TX_PARITY_EN
        // Even parity: 07 has three ones -> 1, 03 has two ones -> 0.
        applyStimulus(8'h07, 1'b0);
        checkFrame(8'h07, -1, "par07");
        checkOutput("par07_parity", midLevel[9], 1);
        applyStimulus(8'h03, 1'b0);
        checkFrame(8'h03, -1, "par03");
        checkOutput("par03_parity", midLevel[9], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
